serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 30 +++
 rtl/serial_add_ctrl_fa_cell.sv | 21 ++
 rtl/serial_add_ctrl.sv | 101 ++++++++++
 tb/tb_serial_add_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller:
// state encodings and the default operand width.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Code 2'd3 is unused and the controller steers it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand and result handshakes of the serial adder.
// The master side is the operand source / result consumer.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational full-adder bit cell made of two half adders and an OR,
// time-shared by the controller across all operand bits.
module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = x ^ y;
  assign h1_c = x & y;
  assign s    = h1_s ^ ci;
  assign h2_c = h1_s & ci;
  assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first,
// one bit per clock, through a single shared full-adder cell.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cout_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             fa_s;
  logic             fa_c;

  serial_fa_cell fa (
    .x  (shift_a[0]),
    .y  (shift_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands in sum_r[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      shift_a     <= '0;
      shift_b     <= '0;
      sum_r       <= '0;
      cnt         <= '0;
      carry       <= 1'b0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            shift_a    <= bus.a;
            shift_b    <= bus.b;
            carry      <= bus.cin;
            cnt        <= '0;
            sum_r      <= '0;
            cout_r     <= 1'b0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
          shift_a <= {1'b0, shift_a[WIDTH-1:1]};
          shift_b <= {1'b0, shift_b[WIDTH-1:1]};
          carry   <= fa_c;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cout_r      <= fa_c;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed corner cases followed by
// 1000 random operand triples checked against plain a+b+cin arithmetic.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCount = 0;
  int resultCount = 0;
  int lastAccept = 0;
  int prevAccept = 0;
  int doneOps = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Handshake monitor: counts accepts and delivered results, timestamps accepts.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        acceptCount <= acceptCount + 1;
        prevAccept  <= lastAccept;
        lastAccept  <= cyc;
      end
      if (bus.out_valid && bus.out_ready)
        resultCount <= resultCount + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input int idle);
    int n0;
    int t;
    bus.in_valid = 1'b0;
    repeat (idle) step();
    bus.a        = av;
    bus.b        = bv;
    bus.cin      = cv;
    bus.in_valid = 1'b1;
    n0 = acceptCount;
    t  = 0;
    while (acceptCount == n0 && t < 100) begin
      step();
      t++;
    end
    bus.in_valid = 1'b0;
    check("accept", 64'(acceptCount), 64'(n0 + 1));
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] es, input logic ec,
                             input int stall, input bit noise);
    int t;
    t = 0;
    bus.out_ready = 1'b0;
    while (!bus.out_valid && t < 100) begin
      if (noise) begin
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.cin      = 1'($urandom);
        bus.in_valid = 1'($urandom);
      end
      step();
      t++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    check({tag, "_sum"}, 64'(bus.sum), 64'(es));
    check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
    repeat (stall) begin
      step();
      check({tag, "_hold_valid"}, 64'(bus.out_valid), 64'(1));
      check({tag, "_hold_sum"}, 64'(bus.sum), 64'(es));
      check({tag, "_hold_cout"}, 64'(bus.cout), 64'(ec));
      check({tag, "_hold_in_ready"}, 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    doneOps++;
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    int busyCycles;
    int edges;
    int n0;
    int t;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   full;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    $display("[TB] reset");
    rst = 1'b1;
    step();
    step();
    check("reset_in_ready", 64'(bus.in_ready), 64'(0));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_sum", 64'(bus.sum), 64'(0));
    check("reset_cout", 64'(bus.cout), 64'(0));
    check("reset_state", 64'(dut.state), 64'(ST_IDLE));
    rst = 1'b0;
    step();
    check("post_reset_in_ready", 64'(bus.in_ready), 64'(1));

    $display("[TB] 35+4A latency and busy window");
    applyStimulus(8'h35, 8'h4A, 1'b0, 0);
    busyCycles = 0;
    edges      = 0;
    while (!bus.out_valid && edges < 50) begin
      if (bus.busy) busyCycles++;
      step();
      edges++;
    end
    check("busy_cycles", 64'(busyCycles), 64'(W));
    // Result visible right after edge N+WIDTH, i.e. sampled by edge N+WIDTH+1.
    check("latency_edges", 64'(edges), 64'(W));
    checkOutput("add_35_4a", 8'h7F, 1'b0, 0, 0);

    $display("[TB] FF+00+1 full ripple");
    applyStimulus(8'hFF, 8'h00, 1'b1, 1);
    checkOutput("ripple", 8'h00, 1'b1, 0, 0);

    $display("[TB] C8+64+1 with backpressure");
    applyStimulus(8'hC8, 8'h64, 1'b1, 0);
    checkOutput("backpressure", 8'h2D, 1'b1, 5, 0);

    $display("[TB] back-to-back");
    bus.out_ready = 1'b1;
    bus.a         = 8'h5A;
    bus.b         = 8'h3C;
    bus.cin       = 1'b0;
    bus.in_valid  = 1'b1;
    n0 = acceptCount;
    t  = 0;
    while (acceptCount != n0 + 1 && t < 100) begin step(); t++; end
    check("b2b_first_accept", 64'(acceptCount), 64'(n0 + 1));
    bus.a   = 8'hA7;
    bus.b   = 8'h91;
    bus.cin = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 100) begin step(); t++; end
    check("b2b_first_valid", 64'(bus.out_valid), 64'(1));
    check("b2b_first_sum", 64'(bus.sum), 64'(8'h96));
    check("b2b_first_cout", 64'(bus.cout), 64'(0));
    t = 0;
    while (acceptCount != n0 + 2 && t < 100) begin step(); t++; end
    bus.in_valid = 1'b0;
    check("b2b_second_accept", 64'(acceptCount), 64'(n0 + 2));
    check("b2b_interval", 64'(lastAccept - prevAccept), 64'(W + 2));
    t = 0;
    while (!bus.out_valid && t < 100) begin step(); t++; end
    check("b2b_second_valid", 64'(bus.out_valid), 64'(1));
    check("b2b_second_sum", 64'(bus.sum), 64'(8'h39));
    check("b2b_second_cout", 64'(bus.cout), 64'(1));
    step();
    bus.out_ready = 1'b0;
    doneOps += 2;
    check("b2b_valid_drop", 64'(bus.out_valid), 64'(0));

    $display("[TB] reset during RUN");
    applyStimulus(8'h12, 8'h34, 1'b0, 0);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check("abort_state", 64'(dut.state), 64'(ST_IDLE));
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_sum", 64'(bus.sum), 64'(0));
    check("abort_cout", 64'(bus.cout), 64'(0));
    rst = 1'b0;
    step();
    check("abort_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_no_result", 64'(bus.out_valid), 64'(0));
    applyStimulus(8'h01, 8'h01, 1'b0, 0);
    checkOutput("after_abort", 8'h02, 1'b0, 0, 0);

    $display("[TB] random operands");
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      applyStimulus(ra, rb, rc, $urandom_range(0, 2));
      checkOutput("rand", full[W-1:0], full[W], $urandom_range(0, 3), 1);
    end

    step();
    check("result_count", 64'(resultCount), 64'(doneOps));
    check("accept_count", 64'(acceptCount), 64'(doneOps + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
